// File: rtl/mult_share_arb.sv
// mult_share_arb: round-robin arbiter and sequencer that shares one 8x8
// sequential multiplier among NREQ requesters and returns tagged products.
module mult_share_arb #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned IDW     = 2,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_a,
    input  logic [8*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]     req_grant,
    output logic                rsp_valid,
    output logic [IDW-1:0]      rsp_id,
    output logic [15:0]         rsp_product,
    output logic                rsp_err,
    output logic                busy,
    output logic                mul_start,
    output logic [7:0]          mul_a,
    output logic [7:0]          mul_b,
    input  logic [15:0]         mul_product,
    input  logic                mul_ready
);

    // WAIT-cycle counter must be able to hold TIMEOUT itself
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [IDW-1:0]    id_q, id_d;
    logic [7:0]        a_q, a_d;
    logic [7:0]        b_q, b_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic              start_q, start_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]    rsp_id_q, rsp_id_d;
    logic [15:0]       prod_q, prod_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;

    logic [7:0]        op_a [NREQ];
    logic [7:0]        op_b [NREQ];
    logic              win_found;
    logic [IDW-1:0]    win_id;

    // Unpack the flat operand buses into per-requester bytes
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign op_a[g] = req_a[8*g +: 8];
        assign op_b[g] = req_b[8*g +: 8];
    end

    // Round-robin pick: first active request at or after the pointer, wrapping
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            int unsigned cand;
            cand = 32'(ptr_q) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!win_found && req_valid[IDW'(cand)]) begin
                win_found = 1'b1;
                win_id    = IDW'(cand);
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        cnt_d       = cnt_q;
        grant_d     = '0;
        start_d     = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        prod_d      = prod_q;
        err_d       = err_q;

        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    id_d    = win_id;
                    a_d     = op_a[win_id];
                    b_d     = op_b[win_id];
                    grant_d = NREQ'(1) << win_id;
                    start_d = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                // Multiplier loads on this edge; the pointer moves past the winner
                cnt_d   = '0;
                ptr_d   = (32'(id_q) == NREQ - 1) ? '0 : IDW'(id_q + IDW'(1));
                state_d = WAIT;
            end
            WAIT: begin
                if (mul_ready) begin
                    prod_d      = mul_product;
                    err_d       = 1'b0;
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    prod_d      = '0;
                    err_d       = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            grant_q     <= '0;
            start_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            prod_q      <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            start_q     <= start_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            prod_q      <= prod_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign req_grant   = grant_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_product = prod_q;
    assign rsp_err     = err_q;
    assign busy        = busy_q;
    assign mul_start   = start_q;
    assign mul_a       = a_q;
    assign mul_b       = b_q;

endmodule

// File: tb/tb_mult_share_arb.sv
// tb_mult_share_arb: directed bench for mult_share_arb with a behavioural
// 8-shift-cycle multiplier that has no reset.
module tb_mult_share_arb;

    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_a;
    logic [8*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_grant;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [15:0]       rsp_product;
    logic              rsp_err;
    logic              busy;
    logic              mul_start;
    logic [7:0]        mul_a;
    logic [7:0]        mul_b;
    logic [15:0]       mul_product;
    logic              mul_ready;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    mult_share_arb #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_grant(req_grant), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_product(rsp_product), .rsp_err(rsp_err), .busy(busy),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_product(mul_product), .mul_ready(mul_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model: loads on start, ready after 8 shift cycles, never reset
    logic [7:0]  m_a = 8'h0, m_b = 8'h0;
    logic [3:0]  m_cnt = 4'd0;
    logic        m_rdy = 1'b0;
    logic [15:0] m_prod = 16'h0;
    logic        stall = 1'b0;

    always @(posedge clk) begin
        if (mul_start) begin
            m_a   <= mul_a;
            m_b   <= mul_b;
            m_cnt <= 4'd8;
            m_rdy <= 1'b0;
        end else if (m_cnt != 4'd0) begin
            m_cnt <= m_cnt - 4'd1;
            if (m_cnt == 4'd1) begin
                m_rdy  <= 1'b1;
                m_prod <= 16'(m_a) * 16'(m_b);
            end
        end
    end
    assign mul_ready   = m_rdy & ~stall;
    assign mul_product = m_prod;

    typedef struct {
        int          id;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic fail_bound(input string name);
        n_chk++;
        $display("FAIL %s: no event within bound (cycle %0d)", name, cyc);
    endtask

    task automatic wait_grant(output int gc, output bit ok);
        ok = 1'b0;
        gc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_grant != '0) begin
                ok = 1'b1;
                gc = cyc;
                break;
            end
        end
        if (!ok) fail_bound("grant_wait");
    endtask

    task automatic wait_rsp(output int rc, output bit ok);
        ok = 1'b0;
        rc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                rc = cyc;
                break;
            end
        end
        if (!ok) fail_bound("rsp_wait");
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One request from one requester, checked from grant to response
    task automatic do_op(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp, input logic err, input int lat);
        int g, r;
        bit ok;
        req_a[8*id +: 8] = a;
        req_b[8*id +: 8] = b;
        req_valid[id]    = 1'b1;
        wait_grant(g, ok);
        if (!ok) begin
            req_valid = '0;
            return;
        end
        check("grant_onehot", 32'(req_grant), 32'(1) << id);
        check("mul_start", 32'(mul_start), 32'd1);
        check("mul_operands", 32'({mul_a, mul_b}), 32'({a, b}));
        req_valid[id] = 1'b0;
        wait_rsp(r, ok);
        if (!ok) return;
        check("rsp_latency", 32'(r - g), 32'(lat));
        check("rsp_id", 32'(rsp_id), 32'(id));
        check("rsp_product", 32'(rsp_product), 32'(exp));
        check("rsp_err", 32'(rsp_err), 32'(err));
        @(negedge clk);
        check("rsp_pulse", 32'(rsp_valid), 32'd0);
        check("rsp_hold", 32'(rsp_product), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ids[5];
        logic [15:0] cprod[4];
        int g, r, prev_g, pulses;
        bit ok;

        vecs[0] = '{0, 8'h0C, 8'h0A, 16'h0078};
        vecs[1] = '{2, 8'hFF, 8'hFF, 16'hFE01};
        vecs[2] = '{2, 8'h00, 8'hFF, 16'h0000};
        vecs[3] = '{1, 8'h12, 8'h34, 16'h03A8};
        vecs[4] = '{3, 8'h80, 8'h02, 16'h0100};
        vecs[5] = '{1, 8'h01, 8'hFF, 16'h00FF};

        ids   = '{0, 1, 2, 3, 0};
        cprod = '{16'h000F, 16'h0100, 16'h01FE, 16'h3872};

        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check("reset_grant", 32'(req_grant), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_mul_start", 32'(mul_start), 32'd0);
        check("reset_product", 32'(rsp_product), 32'd0);
        check("reset_mul_ab", 32'({mul_a, mul_b}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table of single requests
        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0, 10);
        end

        // Timeout abort, then a normal request completes
        stall = 1'b1;
        do_op(1, 8'h21, 8'h03, 16'h0000, 1'b1, TIMEOUT + 2);
        stall = 1'b0;
        do_op(1, 8'h21, 8'h03, 16'h0063, 1'b0, 10);

        // All four requesting continuously
        do_reset();
        req_a = {8'hAA, 8'hFF, 8'h10, 8'h03};
        req_b = {8'h55, 8'h02, 8'h10, 8'h05};
        req_valid = 4'hF;
        prev_g = 0;
        for (int i = 0; i < 5; i++) begin
            wait_grant(g, ok);
            if (!ok) break;
            check("rr_grant", 32'(req_grant), 32'(1) << ids[i]);
            if (i > 0) check("rr_spacing", 32'(g - prev_g), 32'd12);
            prev_g = g;
            if (i == 4) req_valid = '0;
            wait_rsp(r, ok);
            if (!ok) break;
            check("rr_rsp_id", 32'(rsp_id), 32'(ids[i]));
            check("rr_product", 32'(rsp_product), 32'(cprod[ids[i]]));
        end
        req_valid = '0;

        // Fairness after wrap: pointer left at 3 by a grant to requester 2
        do_reset();
        do_op(2, 8'h05, 8'h06, 16'h001E, 1'b0, 10);
        req_a[8*0 +: 8] = 8'h09; req_b[8*0 +: 8] = 8'h09;
        req_a[8*3 +: 8] = 8'h0B; req_b[8*3 +: 8] = 8'h0C;
        req_valid = 4'b1001;
        wait_grant(g, ok);
        check("wrap_first", 32'(req_grant), 32'h8);
        req_valid[3] = 1'b0;
        wait_rsp(r, ok);
        check("wrap_first_id", 32'(rsp_id), 32'd3);
        check("wrap_first_prod", 32'(rsp_product), 32'h0084);
        wait_grant(g, ok);
        check("wrap_second", 32'(req_grant), 32'h1);
        req_valid = '0;
        wait_rsp(r, ok);
        check("wrap_second_id", 32'(rsp_id), 32'd0);
        check("wrap_second_prod", 32'(rsp_product), 32'h0051);

        // Reset in the middle of WAIT
        req_a[8*0 +: 8] = 8'h07; req_b[8*0 +: 8] = 8'h09;
        req_valid[0] = 1'b1;
        wait_grant(g, ok);
        req_valid = '0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_product", 32'(rsp_product), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        check("midrst_no_rsp", 32'(pulses), 32'd0);
        do_op(3, 8'h0B, 8'h0D, 16'h008F, 1'b0, 10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
